// File: rtl/g_poly_loader.sv
// g_poly_loader: streams ternary small-poly coefficients into the g coefficient RAM as Fq words, then zero-pads.
// Latency: each accepted coefficient appears on the RAM write pins one cycle later; start-to-done is PAD_LEN + 2 cycles minimum.
// Backpressure: s_ready is high only while loading; s_valid gaps simply produce idle write cycles. Define G_POLY_LOADER_ERR_EN for the err output.
module g_poly_loader #(
  parameter int RAM_WIDTH     = 13,
  parameter int RAM_ADDR_BITS = 11,
  parameter int P             = 757,
  parameter int Q             = 5167,
  parameter int PAD_LEN       = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [1:0]               s_coef,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     write_enable,
  output logic [RAM_ADDR_BITS-1:0] write_address,
  output logic [RAM_WIDTH-1:0]     input_data,
  output logic                     busy,
  output logic                     done,
`ifdef G_POLY_LOADER_ERR_EN
  output logic                     err,
`endif
  output logic [RAM_ADDR_BITS-1:0] weight
);

  // Address of the final coefficient and of the final padding word.
  localparam logic [RAM_ADDR_BITS-1:0] LAST_COEF  = RAM_ADDR_BITS'(P - 1);
  localparam logic [RAM_ADDR_BITS-1:0] LAST_PAD   = RAM_ADDR_BITS'(PAD_LEN - 1);
  localparam logic [RAM_ADDR_BITS-1:0] WEIGHT_MAX = '1;

  // Canonical Fq representatives of the ternary values.
  localparam logic [RAM_WIDTH-1:0] FQ_ONE       = RAM_WIDTH'(1);
  localparam logic [RAM_WIDTH-1:0] FQ_MINUS_ONE = RAM_WIDTH'(Q - 1);

  // With PAD_LEN == P the pad phase is skipped entirely.
  localparam bit HAS_PAD = (PAD_LEN > P);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PAD  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                   state;
  logic [RAM_ADDR_BITS-1:0] coef_cnt;
  logic                     accept;
  logic                     coef_nonzero;

  // A coefficient is taken only in LOAD on a valid/ready handshake.
  assign accept       = (state == ST_LOAD) && s_valid && s_ready;
  // Only +1 and -1 contribute to the Hamming weight; the invalid code does not.
  assign coef_nonzero = (s_coef == 2'b01) || (s_coef == 2'b11);

  // Ternary code to Fq word: the invalid code 2'b10 lands on zero.
  function automatic logic [RAM_WIDTH-1:0] map_coef(input logic [1:0] c);
    case (c)
      2'b01:   map_coef = FQ_ONE;
      2'b11:   map_coef = FQ_MINUS_ONE;
      default: map_coef = '0;
    endcase
  endfunction

  // Load sequencer: all RAM-side and status outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      coef_cnt      <= '0;
      s_ready       <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      input_data    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      weight        <= '0;
`ifdef G_POLY_LOADER_ERR_EN
      err           <= 1'b0;
`endif
    end else begin
      // Write strobe and done are pulses; address and data hold otherwise.
      write_enable <= 1'b0;
      done         <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            coef_cnt <= '0;
            weight   <= '0;
            busy     <= 1'b1;
            s_ready  <= 1'b1;
            state    <= ST_LOAD;
`ifdef G_POLY_LOADER_ERR_EN
            err      <= 1'b0;
`endif
          end
        end

        ST_LOAD: begin
          if (accept) begin
            write_enable  <= 1'b1;
            write_address <= coef_cnt;
            input_data    <= map_coef(s_coef);
            if (coef_nonzero && (weight != WEIGHT_MAX)) begin
              weight <= weight + 1'b1;
            end
`ifdef G_POLY_LOADER_ERR_EN
            if (s_coef == 2'b10) begin
              err <= 1'b1;
            end
`endif
            if (coef_cnt == LAST_COEF) begin
              // Stop accepting immediately so coefficient P is never taken.
              s_ready <= 1'b0;
              if (HAS_PAD) begin
                coef_cnt <= coef_cnt + 1'b1;
                state    <= ST_PAD;
              end else begin
                state    <= ST_DONE;
              end
            end else begin
              coef_cnt <= coef_cnt + 1'b1;
            end
          end
        end

        ST_PAD: begin
          write_enable  <= 1'b1;
          write_address <= coef_cnt;
          input_data    <= '0;
          if (coef_cnt == LAST_PAD) begin
            state <= ST_DONE;
          end else begin
            coef_cnt <= coef_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          // Last RAM word was captured on this edge; announce completion.
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
